// File: rtl/safecrack_lockout_ctrl.sv
// rtl/safecrack_lockout_ctrl.sv - escalating keypad lockout controller with permanent lock and admin clear
module safecrack_lockout_ctrl #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BASE_LOCK_S = 10,
    parameter int MAX_LOCK_S  = 160,
    parameter int MAX_FAILS   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       attempt_done,
    input  logic       attempt_ok,
    input  logic       admin_clear,
    output logic       input_enable,
    output logic       locked,
    output logic       perm_lock,
    output logic [3:0] fail_count,
    output logic [7:0] lock_remaining,
    output logic       protocol_err
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    typedef enum logic [1:0] {
        ST_OPEN,
        ST_LOCKOUT,
        ST_PERMA
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    fail_q;
    logic [7:0]    rem_q;
    logic          input_enable_q;
    logic          locked_q;
    logic          perm_lock_q;
    logic          protocol_err_q;

    logic [3:0]    fail_inc_d;
    logic [31:0]   shifted_d;
    logic [7:0]    lock_load_d;

    // Failure count after this attempt and its capped lockout duration; the
    // shift is done in 32 bits so large counts cannot wrap before the cap.
    always_comb begin
        fail_inc_d  = fail_q + 4'd1;
        shifted_d   = 32'(BASE_LOCK_S) << (fail_inc_d - 4'd1);
        lock_load_d = (shifted_d > 32'(MAX_LOCK_S)) ? 8'(MAX_LOCK_S) : shifted_d[7:0];
    end

    // Lock state machine with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_OPEN;
            presc_q        <= '0;
            fail_q         <= 4'd0;
            rem_q          <= 8'd0;
            input_enable_q <= 1'b1;
            locked_q       <= 1'b0;
            perm_lock_q    <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            protocol_err_q <= 1'b0;
            if (admin_clear) begin
                // Clear wins over any attempt in the same cycle; that attempt is dropped.
                state_q        <= ST_OPEN;
                presc_q        <= '0;
                fail_q         <= 4'd0;
                rem_q          <= 8'd0;
                input_enable_q <= 1'b1;
                locked_q       <= 1'b0;
                perm_lock_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_OPEN: begin
                        if (attempt_done) begin
                            if (attempt_ok) begin
                                fail_q <= 4'd0;
                            end else begin
                                fail_q <= fail_inc_d;
                                if (fail_inc_d == 4'(MAX_FAILS)) begin
                                    state_q        <= ST_PERMA;
                                    input_enable_q <= 1'b0;
                                    perm_lock_q    <= 1'b1;
                                end else begin
                                    state_q        <= ST_LOCKOUT;
                                    rem_q          <= lock_load_d;
                                    presc_q        <= '0;
                                    input_enable_q <= 1'b0;
                                    locked_q       <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_LOCKOUT: begin
                        protocol_err_q <= attempt_done;
                        if (presc_q == PW'(CLK_FREQ - 1)) begin
                            presc_q <= '0;
                            rem_q   <= rem_q - 8'd1;
                            if (rem_q == 8'd1) begin
                                state_q        <= ST_OPEN;
                                input_enable_q <= 1'b1;
                                locked_q       <= 1'b0;
                            end
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    ST_PERMA: begin
                        protocol_err_q <= attempt_done;
                    end
                    default: begin
                        state_q        <= ST_OPEN;
                        input_enable_q <= 1'b1;
                        locked_q       <= 1'b0;
                        perm_lock_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign input_enable   = input_enable_q;
    assign locked         = locked_q;
    assign perm_lock      = perm_lock_q;
    assign fail_count     = fail_q;
    assign lock_remaining = rem_q;
    assign protocol_err   = protocol_err_q;

endmodule

// File: tb/tb_safecrack_lockout_ctrl.sv
// tb/tb_safecrack_lockout_ctrl.sv - scoreboard bench for safecrack_lockout_ctrl
module tb_safecrack_lockout_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic a_done, a_ok, a_clr;
    logic b_done, b_ok, b_clr;
    logic a_ie, a_lk, a_pl, a_perr;
    logic b_ie, b_lk, b_pl, b_perr;
    logic [3:0] a_fc, b_fc;
    logic [7:0] a_rem, b_rem;

    safecrack_lockout_ctrl #(
        .CLK_FREQ(4), .BASE_LOCK_S(10), .MAX_LOCK_S(160), .MAX_FAILS(5)
    ) dut_a (
        .clk(clk), .rst(rst),
        .attempt_done(a_done), .attempt_ok(a_ok), .admin_clear(a_clr),
        .input_enable(a_ie), .locked(a_lk), .perm_lock(a_pl),
        .fail_count(a_fc), .lock_remaining(a_rem), .protocol_err(a_perr)
    );

    safecrack_lockout_ctrl #(
        .CLK_FREQ(4), .BASE_LOCK_S(10), .MAX_LOCK_S(160), .MAX_FAILS(7)
    ) dut_b (
        .clk(clk), .rst(rst),
        .attempt_done(b_done), .attempt_ok(b_ok), .admin_clear(b_clr),
        .input_enable(b_ie), .locked(b_lk), .perm_lock(b_pl),
        .fail_count(b_fc), .lock_remaining(b_rem), .protocol_err(b_perr)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [15:0] pack(logic ie, logic lk, logic pl, logic [3:0] fc,
                                         logic [7:0] rem, logic perr);
        return {ie, lk, pl, fc, rem, perr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int sel, logic done, logic ok, logic clr);
        if (sel == 0) begin
            a_done = done; a_ok = ok; a_clr = clr;
        end else begin
            b_done = done; b_ok = ok; b_clr = clr;
        end
    endtask

    task automatic expect_out(string tag, int sel, logic ie, logic lk, logic pl,
                              logic [3:0] fc, logic [7:0] rem, logic perr);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = pack(ie, lk, pl, fc, rem, perr);
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [15:0] got;
        e   = sb.pop_front();
        got = (e.sel == 0) ? pack(a_ie, a_lk, a_pl, a_fc, a_rem, a_perr)
                           : pack(b_ie, b_lk, b_pl, b_fc, b_rem, b_perr);
        checks++;
        assert (got === e.val) else begin
            errors++;
            $error("FAIL %s: observed ie/lk/pl/fc/rem/perr=%h expected=%h", e.tag, got, e.val);
        end
    endtask

    // One attempt pulse on the selected instance; outputs are checked after the edge.
    task automatic attempt(int sel, logic ok);
        drive(sel, 1'b1, ok, 1'b0);
        tick();
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    // Counts cycles with input_enable low, starting at the current observation point.
    task automatic wait_open(string tag, int sel, int exp_cycles);
        int cnt = 0;
        while (((sel == 0) ? a_ie : b_ie) !== 1'b1 && cnt < 5000) begin
            cnt++;
            tick();
        end
        checks++;
        assert (cnt == exp_cycles) else begin
            errors++;
            $error("FAIL %s: observed lock cycles=%0d expected=%0d", tag, cnt, exp_cycles);
        end
    endtask

    int dur_a[4] = '{10, 20, 40, 80};
    int dur_b[6] = '{10, 20, 40, 80, 160, 160};

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        expect_out("reset_a", 0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        expect_out("reset_b", 1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        rst = 1'b0;
        check_out();
        check_out();

        // Escalation on instance A: 10, 20, 40, 80 seconds, then permanent lock.
        for (int k = 0; k < 4; k++) begin
            expect_out($sformatf("esc_fail%0d", k + 1), 0, 1'b0, 1'b1, 1'b0, 4'(k + 1), 8'(dur_a[k]), 1'b0);
            attempt(0, 1'b0);
            check_out();
            wait_open($sformatf("esc_dur%0d", k + 1), 0, dur_a[k] * 4);
            expect_out($sformatf("esc_open%0d", k + 1), 0, 1'b1, 1'b0, 1'b0, 4'(k + 1), 8'd0, 1'b0);
            check_out();
        end
        expect_out("esc_perma", 0, 1'b0, 1'b0, 1'b1, 4'd5, 8'd0, 1'b0);
        attempt(0, 1'b0);
        check_out();

        // Attempts while permanently locked are ignored and flagged.
        for (int k = 0; k < 3; k++) begin
            expect_out($sformatf("perma_perr%0d", k), 0, 1'b0, 1'b0, 1'b1, 4'd5, 8'd0, 1'b1);
            attempt(0, 1'b1);
            check_out();
            expect_out($sformatf("perma_idle%0d", k), 0, 1'b0, 1'b0, 1'b1, 4'd5, 8'd0, 1'b0);
            tick();
            check_out();
        end
        expect_out("perma_clear", 0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0);
        check_out();

        // A success resets escalation.
        expect_out("succ_fail", 0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd10, 1'b0);
        attempt(0, 1'b0);
        check_out();
        wait_open("succ_dur", 0, 40);
        expect_out("succ_ok", 0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        attempt(0, 1'b1);
        check_out();
        expect_out("succ_refail", 0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd10, 1'b0);
        attempt(0, 1'b0);
        check_out();

        // Attempt during lockout, then clear racing an attempt.
        expect_out("lock_perr", 0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd10, 1'b1);
        attempt(0, 1'b0);
        check_out();
        expect_out("lock_perr_end", 0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd10, 1'b0);
        tick();
        check_out();
        expect_out("clear_wins", 0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        drive(0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0);
        check_out();

        // Cap on instance B: the 5th and 6th lockouts both hold 160 seconds.
        for (int k = 0; k < 6; k++) begin
            expect_out($sformatf("cap_fail%0d", k + 1), 1, 1'b0, 1'b1, 1'b0, 4'(k + 1), 8'(dur_b[k]), 1'b0);
            attempt(1, 1'b0);
            check_out();
            wait_open($sformatf("cap_dur%0d", k + 1), 1, dur_b[k] * 4);
        end
        expect_out("cap_perma", 1, 1'b0, 1'b0, 1'b1, 4'd7, 8'd0, 1'b0);
        attempt(1, 1'b0);
        check_out();

        // Reset in the middle of a lockout leaves no residual count.
        expect_out("rst_fail", 0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd10, 1'b0);
        attempt(0, 1'b0);
        check_out();
        repeat (12) tick();
        expect_out("rst_at7", 0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd7, 1'b0);
        check_out();
        expect_out("rst_mid_a", 0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        expect_out("rst_mid_b", 1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out();
        check_out();
        expect_out("rst_refail", 0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd10, 1'b0);
        attempt(0, 1'b0);
        check_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
